wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 35 +++
 rtl/wb_port_arbiter.sv | 92 +++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle between the ALU/LU producers, the arbiter and the register file.
// The master side drives the result offers; the slave side is the arbiter.
interface wb_port_arbiter_if #(
    parameter int DATA_BITS = 64
);
    logic                 alu_valid;
    logic [4:0]           alu_rd;
    logic [DATA_BITS-1:0] alu_data;
    logic                 alu_ready;

    logic                 lu_valid;
    logic [4:0]           lu_rd;
    logic [DATA_BITS-1:0] lu_data;
    logic                 lu_ready;

    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [DATA_BITS-1:0] wb_data;
    logic                 wb_sel;

    logic                 lu_pending;
    logic [4:0]           lu_pending_rd;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
        output alu_ready, lu_ready, wb_en, wb_rd, wb_data, wb_sel,
        output lu_pending, lu_pending_rd
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lu_valid, lu_rd, lu_data,
        input  alu_ready, lu_ready, wb_en, wb_rd, wb_data, wb_sel,
        input  lu_pending, lu_pending_rd
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Two-source writeback arbiter. ALU results win by default and go straight to the write port.
// LU results pass through a one-entry hold buffer, and a starve counter bounds how long they can wait.
module wb_port_arbiter #(
    parameter int DATA_BITS  = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    wb_port_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic                 buf_valid;
    logic [4:0]           buf_rd;
    logic [DATA_BITS-1:0] buf_data;
    logic [3:0]           starve_cnt;

    logic                 wb_en_q;
    logic                 wb_sel_q;
    logic [4:0]           wb_rd_q;
    logic [DATA_BITS-1:0] wb_data_q;

    logic force_lu;
    logic alu_grant;
    logic buf_grant;
    logic lu_accept;

    // The buffer drains when it is granted, so it can also take a new LU result in that same cycle.
    always_comb begin
        force_lu  = buf_valid && (starve_cnt == STARVE_LIM);
        alu_grant = bus.alu_valid && !force_lu;
        buf_grant = buf_valid && !alu_grant;
        lu_accept = bus.lu_valid && (!buf_valid || buf_grant);
    end

    assign bus.alu_ready     = !force_lu;
    assign bus.lu_ready      = !buf_valid || buf_grant;
    assign bus.lu_pending    = buf_valid;
    assign bus.lu_pending_rd = buf_rd;
    assign bus.wb_en         = wb_en_q;
    assign bus.wb_sel        = wb_sel_q;
    assign bus.wb_rd         = wb_rd_q;
    assign bus.wb_data       = wb_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else if (lu_accept) begin
            buf_valid <= 1'b1;
            buf_rd    <= bus.lu_rd;
            buf_data  <= bus.lu_data;
        end else if (buf_grant) begin
            buf_valid <= 1'b0;
        end
    end

    // Counts ALU wins only while an LU result is waiting; force_lu blocks any increment past the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!buf_valid || buf_grant) begin
            starve_cnt <= '0;
        end else if (alu_grant && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_sel_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else if (alu_grant) begin
            wb_en_q   <= (bus.alu_rd != 5'd0);
            wb_sel_q  <= 1'b0;
            wb_rd_q   <= bus.alu_rd;
            wb_data_q <= bus.alu_data;
        end else if (buf_grant) begin
            wb_en_q   <= (buf_rd != 5'd0);
            wb_sel_q  <= 1'b1;
            wb_rd_q   <= buf_rd;
            wb_data_q <= buf_data;
        end else begin
            wb_en_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: each expected write is queued with the cycle it must appear in,
// and a negedge monitor pops and compares every write the DUT issues.
module tb_wb_port_arbiter;

    localparam int DATA_BITS = 64;

    typedef struct {
        int          cycle;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        sel;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];

    wb_port_arbiter_if #(.DATA_BITS(DATA_BITS)) bus ();

    wb_port_arbiter #(.DATA_BITS(DATA_BITS), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                                 input logic lv, input logic [4:0] lrd, input logic [63:0] ld);
        @(posedge clk);
        #2;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lu_valid  = lv;
        bus.lu_rd     = lrd;
        bus.lu_data   = ld;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic expectWrite(input int at, input logic [4:0] rd, input logic [63:0] data, input logic sel);
        wr_t e;
        e.cycle = at;
        e.rd    = rd;
        e.data  = data;
        e.sel   = sel;
        exp_q.push_back(e);
    endtask

    // Write outputs are registered, so the falling edge sees this cycle's settled values.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bus.wb_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_wr_en", 64'(bus.wb_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("wr_cycle", 64'(cyc), 64'(e.cycle));
                checkOutput("wr_rd", 64'(bus.wb_rd), 64'(e.rd));
                checkOutput("wr_data", bus.wb_data, e.data);
                checkOutput("wr_sel", 64'(bus.wb_sel), 64'(e.sel));
            end
        end else if (exp_q.size() != 0 && exp_q[0].cycle <= cyc) begin
            checkOutput("missing_wr_en", 64'(bus.wb_en), 64'd1);
            e = exp_q.pop_front();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.lu_valid  = 1'b0;
        bus.lu_rd     = '0;
        bus.lu_data   = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_wb_en", 64'(bus.wb_en), 64'd0);
        checkOutput("rst_wb_sel", 64'(bus.wb_sel), 64'd0);
        checkOutput("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        checkOutput("rst_wb_data", bus.wb_data, 64'd0);
        checkOutput("rst_lu_pending", 64'(bus.lu_pending), 64'd0);
        checkOutput("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        checkOutput("rst_lu_ready", 64'(bus.lu_ready), 64'd1);
        rst_n = 1'b1;
        idle(2);

        // Single ALU write, one cycle after accept.
        applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        #1;
        checkOutput("alu_ready_single", 64'(bus.alu_ready), 64'd1);
        expectWrite(cyc + 1, 5'd5, 64'h1234, 1'b0);
        idle(3);

        // Single LU write, two cycles after accept through the hold buffer.
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hDEADBEEF);
        #1;
        checkOutput("lu_ready_single", 64'(bus.lu_ready), 64'd1);
        expectWrite(cyc + 2, 5'd7, 64'hDEADBEEF, 1'b1);
        idle(1);
        #1;
        checkOutput("lu_pending_single", 64'(bus.lu_pending), 64'd1);
        checkOutput("lu_pending_rd_single", 64'(bus.lu_pending_rd), 64'd7);
        idle(1);
        #1;
        checkOutput("lu_pending_drained", 64'(bus.lu_pending), 64'd0);
        idle(2);

        // Starvation: four ALU wins over a waiting LU result, one forced LU slot, then ALU resumes.
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'hA5A5_0009);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(10 + k), 64'h100 + 64'(k), 1'b0, 5'd0, 64'd0);
            #1;
            checkOutput($sformatf("starve_alu_ready_%0d", i), 64'(bus.alu_ready), (i == 4) ? 64'd0 : 64'd1);
            checkOutput($sformatf("starve_lu_ready_%0d", i), 64'(bus.lu_ready), (i >= 4) ? 64'd1 : 64'd0);
            checkOutput($sformatf("starve_pending_%0d", i), 64'(bus.lu_pending), (i <= 4) ? 64'd1 : 64'd0);
            if (i == 4) begin
                expectWrite(cyc + 1, 5'd9, 64'hA5A5_0009, 1'b1);
            end else begin
                expectWrite(cyc + 1, 5'(10 + k), 64'h100 + 64'(k), 1'b0);
                k++;
            end
        end
        idle(3);

        // Back-to-back LU results drain and refill the buffer every cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'(20 + i), 64'hBB00 + 64'(i));
            #1;
            checkOutput($sformatf("b2b_lu_ready_%0d", i), 64'(bus.lu_ready), 64'd1);
            expectWrite(cyc + 2, 5'(20 + i), 64'hBB00 + 64'(i), 1'b1);
        end
        idle(4);

        // Results targeting x0 are consumed without a write.
        applyStimulus(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
        #1;
        checkOutput("x0_alu_ready", 64'(bus.alu_ready), 64'd1);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h66);
        idle(1);
        #1;
        checkOutput("x0_lu_pending", 64'(bus.lu_pending), 64'd1);
        idle(1);
        #1;
        checkOutput("x0_lu_drained", 64'(bus.lu_pending), 64'd0);
        checkOutput("x0_wb_en", 64'(bus.wb_en), 64'd0);
        idle(2);

        // Reset with an LU result buffered and an ALU write on the port.
        applyStimulus(1'b1, 5'd4, 64'h44, 1'b1, 5'd12, 64'hC0FFEE);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_wb_en", 64'(bus.wb_en), 64'd1);
        checkOutput("pre_rst_pending", 64'(bus.lu_pending), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_pending", 64'(bus.lu_pending), 64'd0);
        checkOutput("mid_rst_wb_en", 64'(bus.wb_en), 64'd0);
        checkOutput("mid_rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        checkOutput("mid_rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        checkOutput("mid_rst_lu_ready", 64'(bus.lu_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("held_rst_pending", 64'(bus.lu_pending), 64'd0);
        checkOutput("held_rst_wb_en", 64'(bus.wb_en), 64'd0);
        bus.alu_valid = 1'b0;
        bus.lu_valid  = 1'b0;
        rst_n = 1'b1;
        idle(4);
        #1;
        checkOutput("post_rst_pending", 64'(bus.lu_pending), 64'd0);

        idle(2);
        checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
